// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter.
// Merges in-order pipeline writeback (RegWriteP/RdP/ResultP) with out-of-order
// late results (late_valid/late_ready/late_rd/late_data) that are queued in a
// DEPTH-entry FIFO. A per-register pending scoreboard is set by issue_valid/
// issue_rd and cleared when the late result is written. Decode reads it through
// A1/A2 -> hazard1/hazard2.
// Outputs:
//   RegWriteW/RdW/ResultW - registered write port.
//   stall_req             - freezes the pipeline WB register when the FIFO must drain.
//   fifo_count            - current queue occupancy.
module wb_write_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RegWriteP,
  input  logic [4:0]             RdP,
  input  logic [31:0]            ResultP,
  input  logic                   late_valid,
  output logic                   late_ready,
  input  logic [4:0]             late_rd,
  input  logic [31:0]            late_data,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  input  logic [4:0]             A1,
  input  logic [4:0]             A2,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic                   stall_req,
  output logic                   RegWriteW,
  output logic [4:0]             RdW,
  output logic [31:0]            ResultW,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } late_entry_t;

  late_entry_t   mem [DEPTH];
  late_entry_t   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;
  logic          empty;
  logic          full;
  logic          pipe_win;
  logic          push;
  logic          pop;

  // Arbitration decisions, all from registered state plus current inputs
  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign late_ready = !rst && !full;
  assign stall_req  = full || (starve_cnt == SW'(STARVE_MAX));
  assign pipe_win   = !stall_req && RegWriteP && (RdP != 5'd0);
  assign pop        = !pipe_win && !empty;
  // Results for x0 are accepted but never stored
  assign push       = late_valid && late_ready && (late_rd != 5'd0);

  assign fifo_count = count;
  assign hazard1    = pending[A1];
  assign hazard2    = pending[A2];

  // Scoreboard update: clear on pop first so a same-cycle issue wins
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head.rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // FIFO storage (no reset needed; validity tracked by pointers/count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= late_entry_t'{rd: late_rd, data: late_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Starvation counter: counts pipeline wins over a waiting FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Pending scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // Registered write port; address/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      RdW       <= 5'd0;
      ResultW   <= 32'd0;
    end else if (pipe_win) begin
      RegWriteW <= 1'b1;
      RdW       <= RdP;
      ResultW   <= ResultP;
    end else if (pop) begin
      RegWriteW <= 1'b1;
      RdW       <= head.rd;
      ResultW   <= head.data;
    end else begin
      RegWriteW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios followed by a
// random run, all compared against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 8;
  localparam int unsigned CW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RegWriteP = 1'b0;
  logic [4:0]    RdP = '0;
  logic [31:0]   ResultP = '0;
  logic          late_valid = 1'b0;
  logic          late_ready;
  logic [4:0]    late_rd = '0;
  logic [31:0]   late_data = '0;
  logic          issue_valid = 1'b0;
  logic [4:0]    issue_rd = '0;
  logic [4:0]    A1 = '0;
  logic [4:0]    A2 = '0;
  logic          hazard1, hazard2, stall_req, RegWriteW;
  logic [4:0]    RdW;
  logic [31:0]   ResultW;
  logic [CW-1:0] fifo_count;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .RegWriteP(RegWriteP), .RdP(RdP), .ResultP(ResultP),
    .late_valid(late_valid), .late_ready(late_ready),
    .late_rd(late_rd), .late_data(late_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .A1(A1), .A2(A2), .hazard1(hazard1), .hazard2(hazard2),
    .stall_req(stall_req), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit   [31:0] pend;
  int          starve;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_res;

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend   = '0;
    starve = 0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_res  = '0;
  endtask

  // One clock edge of the write-port rules, from inputs present before the edge
  task automatic model_edge();
    int   cnt;
    bit   stall, ready, pipe;
    ent_t e;
    cnt   = q.size();
    stall = (cnt == DEPTH) || (starve == STARVE_MAX);
    ready = (cnt < DEPTH);
    pipe  = !stall && RegWriteP && (RdP != 0);
    if (pipe) begin
      m_we = 1'b1; m_rd = RdP; m_res = ResultP;
      starve = (cnt == 0) ? 0 : ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX);
    end else if (cnt > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_res = e.data;
      pend[e.rd] = 1'b0;
      starve = 0;
    end else begin
      m_we = 1'b0;
      starve = 0;
    end
    if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
    if (late_valid && ready && late_rd != 0) q.push_back('{rd: late_rd, data: late_data});
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".RegWriteW"},  32'(RegWriteW),  32'(m_we));
    chk({tag, ".RdW"},        32'(RdW),        32'(m_rd));
    chk({tag, ".ResultW"},    ResultW,         m_res);
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".late_ready"}, 32'(late_ready), 32'(!rst && q.size() < DEPTH));
    chk({tag, ".stall_req"},  32'(stall_req),
        32'((q.size() == DEPTH) || (starve == STARVE_MAX)));
    chk({tag, ".hazard1"},    32'(hazard1),    32'(pend[A1]));
    chk({tag, ".hazard2"},    32'(hazard2),    32'(pend[A2]));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int pop_edge;
    int seen;
    logic [4:0] order [4];

    model_reset();
    // Reset state
    #1;
    chk("rst.RegWriteW",  32'(RegWriteW),  32'd0);
    chk("rst.RdW",        32'(RdW),        32'd0);
    chk("rst.ResultW",    ResultW,         32'd0);
    chk("rst.late_ready", 32'(late_ready), 32'd0);
    chk("rst.stall_req",  32'(stall_req),  32'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.late_ready", 32'(late_ready), 32'd1);

    // Pipeline only
    RegWriteP = 1'b1; RdP = 5'd3; ResultP = 32'hDEADBEEF;
    tick("pipe");
    chk("pipe.RdW",     32'(RdW), 32'd3);
    chk("pipe.ResultW", ResultW,  32'hDEADBEEF);
    RdP = 5'd0;
    tick("pipe_x0");
    chk("pipe_x0.RegWriteW", 32'(RegWriteW), 32'd0);
    RegWriteP = 1'b0;

    // Late result on an idle pipeline
    issue_valid = 1'b1; issue_rd = 5'd7; A1 = 5'd7;
    tick("late_issue");
    issue_valid = 1'b0;
    chk("late_issue.hazard1", 32'(hazard1), 32'd1);
    late_valid = 1'b1; late_rd = 5'd7; late_data = 32'h42;
    tick("late_push");
    late_valid = 1'b0;
    chk("late_push.hazard1",   32'(hazard1),   32'd1);
    chk("late_push.RegWriteW", 32'(RegWriteW), 32'd0);
    tick("late_write");
    chk("late_write.RdW",     32'(RdW),     32'd7);
    chk("late_write.ResultW", ResultW,      32'h42);
    chk("late_write.hazard1", 32'(hazard1), 32'd0);

    // Contention: one queued result under continuous pipeline writes
    RegWriteP = 1'b1; RdP = 5'd2; ResultP = 32'h1;
    late_valid = 1'b1; late_rd = 5'd20; late_data = 32'h2020;
    tick("cont_push");
    late_valid = 1'b0;
    pop_edge = 0;
    for (int k = 1; k <= 12; k++) begin
      RdP = 5'($urandom_range(1, 19)); ResultP = $urandom;
      tick("cont");
      if (pop_edge == 0 && RegWriteW && RdW == 5'd20) pop_edge = k;
    end
    chk("cont.pop_edge", 32'(pop_edge), 32'd9);

    // Full FIFO, drained in order while the pipeline keeps writing
    for (int i = 0; i < 4; i++) begin
      RdP = 5'd1; ResultP = $urandom;
      late_valid = 1'b1; late_rd = 5'(10 + i); late_data = 32'h1000 + 32'(i);
      tick("full_push");
    end
    late_valid = 1'b0;
    chk("full.late_ready", 32'(late_ready), 32'd0);
    chk("full.stall_req",  32'(stall_req),  32'd1);
    seen = 0;
    for (int k = 0; k < 60 && seen < 4; k++) begin
      ResultP = $urandom;
      tick("full_drain");
      if (RegWriteW && RdW >= 5'd10 && RdW <= 5'd13) begin
        order[seen] = RdW;
        seen++;
      end
    end
    chk("full.drained", 32'(seen), 32'd4);
    for (int i = 0; i < 4; i++) chk("full.order", 32'(order[i]), 32'(10 + i));
    RegWriteP = 1'b0;

    // Boundaries: x0 late result, then same-cycle issue and pop of x9
    late_valid = 1'b1; late_rd = 5'd0; late_data = 32'h5;
    tick("x0_late");
    chk("x0_late.fifo_count", 32'(fifo_count), 32'd0);
    chk("x0_late.RegWriteW",  32'(RegWriteW),  32'd0);
    late_rd = 5'd9; late_data = 32'h99;
    tick("x9_push");
    late_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9; A1 = 5'd9;
    tick("x9_pop_issue");
    issue_valid = 1'b0;
    chk("x9.RdW",     32'(RdW),     32'd9);
    chk("x9.hazard1", 32'(hazard1), 32'd1);

    // Async reset mid-cycle with two entries queued and x5 pending
    RegWriteP = 1'b1; RdP = 5'd1; ResultP = 32'h11;
    issue_valid = 1'b1; issue_rd = 5'd5;
    late_valid = 1'b1; late_rd = 5'd5; late_data = 32'hAA;
    tick("rst_fill0");
    issue_valid = 1'b0;
    late_rd = 5'd6; late_data = 32'hBB;
    tick("rst_fill1");
    late_valid = 1'b0; A1 = 5'd5;
    #1;
    chk("rst_fill.fifo_count", 32'(fifo_count), 32'd2);
    chk("rst_fill.hazard1",    32'(hazard1),    32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.RegWriteW",  32'(RegWriteW),  32'd0);
    chk("arst.RdW",        32'(RdW),        32'd0);
    chk("arst.ResultW",    ResultW,         32'd0);
    chk("arst.fifo_count", 32'(fifo_count), 32'd0);
    chk("arst.hazard1",    32'(hazard1),    32'd0);
    model_reset();
    RegWriteP = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_rel.late_ready", 32'(late_ready), 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      RegWriteP   = ($urandom_range(0, 9) < 7);
      RdP         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ResultP     = $urandom;
      late_valid  = ($urandom_range(0, 3) == 0);
      late_rd     = 5'($urandom_range(0, 31));
      late_data   = $urandom;
      issue_valid = ($urandom_range(0, 4) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      A1          = 5'($urandom_range(0, 31));
      A2          = 5'($urandom_range(0, 31));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
